piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/dff_cell.sv | 29 ++
 rtl/piso_serializer.sv | 102 ++++++++++
 tb/tb_piso_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t       : FSM state encoding (IDLE = no word in flight, SHIFT = word in flight)
//   DEFAULT_WIDTH : default parallel word width
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/dff_cell.sv
// One shift-register bit: D flip-flop with async active-high reset and a
// load-enable mux selecting between a parallel load value and the shift input.
// Ports:
//   clk        : clock, rising edge
//   rst        : async active-high reset, clears o_q
//   i_en       : update enable; o_q holds when low
//   i_load     : 1 = take i_load_d, 0 = take i_shift_d
//   i_load_d   : parallel load bit
//   i_shift_d  : bit shifted in from the neighbouring cell
//   o_q        : registered bit
module dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_load,
  input  logic i_load_d,
  input  logic i_shift_d,
  output logic o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= 1'b0;
    end else if (i_en) begin
      o_q <= i_load ? i_load_d : i_shift_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer.
// Handshake: a word is loaded on a rising edge where load_valid && load_ready;
// load_valid is ignored while load_ready is 0. load_ready is high in IDLE and in
// the cycle carrying the last bit, so words can stream back-to-back with no gap.
// Ports:
//   clk         : clock, rising edge
//   rst         : async active-high reset
//   din         : parallel word (sampled only at the load edge)
//   load_valid  : din holds a word to load
//   load_ready  : block accepts a word this cycle
//   sout        : serial bit (0 when sout_valid is 0)
//   sout_valid  : sout is a valid bit
//   done        : pulse on the last bit of a word
//   dbg_state   : current FSM state (0 = IDLE, 1 = SHIFT)
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // The bit presented on sout is the end of the register that shifts out.
  localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] w_q;
  logic            w_shift;
  logic            w_last;
  logic            w_ready;
  logic            w_load;
  logic            w_en;

  assign w_shift = (r_state == ST_SHIFT);
  assign w_last  = w_shift && (r_cnt == LAST);
  assign w_ready = !w_shift || w_last;
  assign w_load  = load_valid && w_ready;
  // Cells keep shifting in SHIFT; the final shift on the last-bit edge
  // drains the register to all zeros when no new word follows.
  assign w_en    = w_load || w_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
    end else if (w_last) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    logic w_shift_d;
    if (LSB_FIRST) begin : g_lsb
      if (j == WIDTH - 1) begin : g_end
        assign w_shift_d = 1'b0;
      end else begin : g_mid
        assign w_shift_d = w_q[j+1];
      end
    end else begin : g_msb
      if (j == 0) begin : g_end
        assign w_shift_d = 1'b0;
      end else begin : g_mid
        assign w_shift_d = w_q[j-1];
      end
    end

    dff_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_en),
      .i_load    (w_load),
      .i_load_d  (din[j]),
      .i_shift_d (w_shift_d),
      .o_q       (w_q[j])
    );
  end

  assign sout       = w_shift & w_q[OUT_IDX];
  assign sout_valid = w_shift;
  assign done       = w_last;
  assign load_ready = w_ready;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut a: WIDTH=8 MSB first
  logic [7:0] a_din = '0;
  logic       a_lv = 1'b0;
  logic       a_rdy, a_sout, a_sv, a_done, a_st;
  // dut b: WIDTH=8 LSB first
  logic [7:0] b_din = '0;
  logic       b_lv = 1'b0;
  logic       b_rdy, b_sout, b_sv, b_done, b_st;
  // dut c: WIDTH=2 MSB first
  logic [1:0] c_din = '0;
  logic       c_lv = 1'b0;
  logic       c_rdy, c_sout, c_sv, c_done, c_st;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .din(a_din), .load_valid(a_lv), .load_ready(a_rdy),
    .sout(a_sout), .sout_valid(a_sv), .done(a_done), .dbg_state(a_st)
  );
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .din(b_din), .load_valid(b_lv), .load_ready(b_rdy),
    .sout(b_sout), .sout_valid(b_sv), .done(b_done), .dbg_state(b_st)
  );
  piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .din(c_din), .load_valid(c_lv), .load_ready(c_rdy),
    .sout(c_sout), .sout_valid(c_sv), .done(c_done), .dbg_state(c_st)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  // Reference model for dut a: the bits still to be shown on sout,
  // front = bit on sout this cycle.
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic lv, input logic [7:0] d);
    a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;
    case (sel)
      0: begin a_lv = lv; a_din = d; end
      1: begin b_lv = lv; b_din = d; end
      default: begin c_lv = lv; c_din = d[1:0]; end
    endcase
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model edge: a word is accepted when at most its last bit remains.
  task automatic model_edge(input logic lv, input logic [7:0] d);
    bit rdy;
    rdy = (exp_q.size() <= 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (lv && rdy) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endtask

  task automatic check_model();
    logic e_sout;
    e_sout = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    check("rnd_sout",  {31'd0, a_sout}, {31'd0, e_sout});
    check("rnd_valid", {31'd0, a_sv},   {31'd0, exp_q.size() > 0});
    check("rnd_done",  {31'd0, a_done}, {31'd0, exp_q.size() == 1});
    check("rnd_ready", {31'd0, a_rdy},  {31'd0, exp_q.size() <= 1});
    check("rnd_state", {31'd0, a_st},   {31'd0, exp_q.size() > 0});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic       lv;
    logic [7:0] din;
    logic       e_sout;
    logic       e_valid;
    logic       e_done;
    logic       e_ready;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int s, input logic lv, input logic [7:0] d,
                     input logic es, input logic ev, input logic ed, input logic er);
    vec_t v;
    v.sel = s; v.lv = lv; v.din = d;
    v.e_sout = es; v.e_valid = ev; v.e_done = ed; v.e_ready = er;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    logic s, v, d, r;
    int done_cnt;

    // Row k gives inputs for the edge and the outputs expected after it.
    // dut a: 8'hA5 MSB first -> 1,0,1,0,0,1,0,1
    add(0, 1, 8'hA5, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 1, 1);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // dut b: 8'h01 LSB first -> 1 then seven 0s, then idle
    add(1, 1, 8'h01, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 8'h00, 0, 1, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 1);
    // dut c: WIDTH=2, 2'b10 then 2'b01 back-to-back -> 1,0,0,1
    add(2, 1, 8'h02, 1, 1, 0, 0);
    add(2, 0, 8'h00, 0, 1, 1, 1);
    add(2, 1, 8'h01, 0, 1, 0, 0);
    add(2, 0, 8'h00, 1, 1, 1, 1);
    add(2, 0, 8'h00, 0, 0, 0, 1);

    // ---- reset state (asynchronous: before any clock edge) ----
    #1 rst = 1'b1;
    #1;
    check("rst_a", {28'd0, a_sout, a_sv, a_done, a_rdy}, 32'h1);
    check("rst_b", {28'd0, b_sout, b_sv, b_done, b_rdy}, 32'h1);
    check("rst_c", {28'd0, c_sout, c_sv, c_done, c_rdy}, 32'h1);
    tick(); tick();
    rst = 1'b0;

    // ---- table ----
    foreach (tbl[k]) begin
      drive(tbl[k].sel, tbl[k].lv, tbl[k].din);
      tick();
      case (tbl[k].sel)
        0: begin s = a_sout; v = a_sv; d = a_done; r = a_rdy; end
        1: begin s = b_sout; v = b_sv; d = b_done; r = b_rdy; end
        default: begin s = c_sout; v = c_sv; d = c_done; r = c_rdy; end
      endcase
      check($sformatf("tbl%0d_sout", k),  {31'd0, s}, {31'd0, tbl[k].e_sout});
      check($sformatf("tbl%0d_valid", k), {31'd0, v}, {31'd0, tbl[k].e_valid});
      check($sformatf("tbl%0d_done", k),  {31'd0, d}, {31'd0, tbl[k].e_done});
      check($sformatf("tbl%0d_ready", k), {31'd0, r}, {31'd0, tbl[k].e_ready});
    end
    drive(0, 0, 8'h00);

    // ---- back-to-back: A5 then 3C held on load_valid ----
    pat = 16'hA53C;
    drive(0, 1, 8'hA5);
    tick();
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("b2b_c%0d_sout", c),  {31'd0, a_sout}, {31'd0, pat[16-c]});
      check($sformatf("b2b_c%0d_valid", c), {31'd0, a_sv}, 32'd1);
      check($sformatf("b2b_c%0d_done", c),  {31'd0, a_done}, {31'd0, (c == 8) || (c == 16)});
      drive(0, (c < 16), 8'h3C);
      tick();
    end
    check("b2b_idle_valid", {31'd0, a_sv}, 32'd0);

    // ---- load_valid ignored while busy ----
    drive(0, 1, 8'h00);
    tick();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("busy_c%0d_sout", c),  {31'd0, a_sout}, 32'd0);
      check($sformatf("busy_c%0d_ready", c), {31'd0, a_rdy}, {31'd0, c == 8});
      drive(0, (c < 8), 8'hFF);
      tick();
    end
    check("busy_idle_valid", {31'd0, a_sv}, 32'd0);
    check("busy_idle_sout",  {31'd0, a_sout}, 32'd0);

    // ---- reset mid-word at bit 3 of 8'hFF ----
    drive(0, 1, 8'hFF);
    tick();
    drive(0, 0, 8'h00);
    tick(); tick(); tick();
    check("mid_pre_valid", {30'd0, a_sv, a_sout}, 32'h3);
    #3 rst = 1'b1;
    #1;
    check("mid_async", {28'd0, a_sout, a_sv, a_done, a_rdy}, 32'h1);
    tick();
    check("mid_held", {28'd0, a_sout, a_sv, a_done, a_rdy}, 32'h1);
    rst = 1'b0;
    // First edge after reset must accept a load; C3 = 1100_0011.
    pat = 16'h00C3;
    drive(0, 1, 8'hC3);
    tick();
    drive(0, 0, 8'h00);
    done_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("post_c%0d_sout", c), {31'd0, a_sout}, {31'd0, pat[8-c]});
      check($sformatf("post_c%0d_done", c), {31'd0, a_done}, {31'd0, c == 8});
      tick();
    end
    check("post_idle", {30'd0, a_sv, a_done}, 32'd0);

    // ---- randomized against the queue model ----
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      logic lv;
      logic [7:0] dd;
      lv = ($urandom_range(0, 3) != 0);
      dd = 8'($urandom);
      model_edge(lv, dd);
      drive(0, lv, dd);
      tick();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
